// File: rtl/rv_alu_issue_pkg.sv
// rv_defs: definitions shared between the decode/issue stage and rv_alu.
//   alu_op_e   4-bit ALU opcode encoding (the op_in contract with rv_alu)
//   OPC_*      RV32I major opcodes handled by the issue stage
//   F7_*       funct7 values that select base / alternate operations
//   issue_t    registered issue bundle presented to the execute stage
package rv_defs;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b0001,
        ALU_XOR  = 4'b0010,
        ALU_OR   = 4'b0011,
        ALU_AND  = 4'b0100,
        ALU_SLL  = 4'b0101,
        ALU_SRL  = 4'b0111,
        ALU_SRA  = 4'b1000,
        ALU_SLT  = 4'b1001,
        ALU_SLTU = 4'b1010
    } alu_op_e;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef struct packed {
        alu_op_e     alu_op;
        logic [31:0] op_a;
        logic [31:0] op_b;
        logic [4:0]  rd_addr;
        logic        illegal;
    } issue_t;

    // Base operation selected by funct3; SUB/SRA overrides are applied by the decoder.
    function automatic alu_op_e funct3_to_alu(input logic [2:0] funct3);
        alu_op_e op;
        case (funct3)
            3'b000:  op = ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/rv_alu_issue_regfile.sv
// rv_regfile: integer register file for the issue stage.
//   clk, rst              clock, synchronous active-high reset (clears all registers)
//   wb_en/wb_addr/wb_data single write port; writes to x0 are dropped
//   rs1_addr/rs1_data     read port 1, combinational with write-to-read bypass
//   rs2_addr/rs2_data     read port 2, combinational with write-to-read bypass
module rv_regfile
    import rv_defs::*;
#(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wb_en,
    input  logic [4:0]      wb_addr,
    input  logic [XLEN-1:0] wb_data,
    input  logic [4:0]      rs1_addr,
    output logic [XLEN-1:0] rs1_data,
    input  logic [4:0]      rs2_addr,
    output logic [XLEN-1:0] rs2_data
);

    logic [XLEN-1:0] regs_q [NREGS];
    logic [XLEN-1:0] regs_d [NREGS];

    always_comb begin
        regs_d = regs_q;
        if (wb_en && (wb_addr != '0)) begin
            regs_d[wb_addr] = wb_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            regs_q <= '{default: '0};
        end else begin
            regs_q <= regs_d;
        end
    end

    // x0 is masked on read, so regs_q[0] never needs to be special-cased on write.
    assign rs1_data = (rs1_addr == '0) ? '0 :
                      (wb_en && (wb_addr == rs1_addr)) ? wb_data : regs_q[rs1_addr];
    assign rs2_data = (rs2_addr == '0) ? '0 :
                      (wb_en && (wb_addr == rs2_addr)) ? wb_data : regs_q[rs2_addr];

endmodule

// File: rtl/rv_alu_issue.sv
// rv_alu_issue: RV32I OP / OP-IMM decode and issue stage feeding rv_alu.
//   clk, rst                       clock, synchronous active-high reset
//   instr_valid/instr/instr_ready  instruction input handshake
//   wb_en/wb_addr/wb_data          register-file writeback port
//   flush                          drops the held issue bundle (and any same-cycle accept)
//   issue_valid/issue_ready        issue bundle handshake to execute
//   alu_op/op_a/op_b/rd_addr/illegal  registered issue bundle
module rv_alu_issue
    import rv_defs::*;
#(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            instr_valid,
    input  logic [31:0]     instr,
    output logic            instr_ready,
    input  logic            wb_en,
    input  logic [4:0]      wb_addr,
    input  logic [XLEN-1:0] wb_data,
    input  logic            flush,
    output logic            issue_valid,
    input  logic            issue_ready,
    output logic [3:0]      alu_op,
    output logic [XLEN-1:0] op_a,
    output logic [XLEN-1:0] op_b,
    output logic [4:0]      rd_addr,
    output logic            illegal
);

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic            accept;
    logic            legal;
    alu_op_e         dec_op;
    logic [XLEN-1:0] dec_b;
    issue_t          dec;
    issue_t          issue_d, issue_q;
    logic            issue_valid_d, issue_valid_q;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];

    rv_regfile #(.XLEN(XLEN), .NREGS(NREGS)) u_regfile (
        .clk      (clk),
        .rst      (rst),
        .wb_en    (wb_en),
        .wb_addr  (wb_addr),
        .wb_data  (wb_data),
        .rs1_addr (instr[19:15]),
        .rs1_data (rs1_data),
        .rs2_addr (instr[24:20]),
        .rs2_data (rs2_data)
    );

    assign instr_ready = !issue_valid_q || issue_ready;
    assign accept      = instr_valid && instr_ready;

    always_comb begin
        legal  = 1'b0;
        dec_op = funct3_to_alu(funct3);
        dec_b  = rs2_data;
        case (opcode)
            OPC_OP: begin
                if (funct7 == F7_BASE) begin
                    legal = 1'b1;
                end else if (funct7 == F7_ALT && funct3 == 3'b000) begin
                    legal  = 1'b1;
                    dec_op = ALU_SUB;
                end else if (funct7 == F7_ALT && funct3 == 3'b101) begin
                    legal  = 1'b1;
                    dec_op = ALU_SRA;
                end
            end
            OPC_OP_IMM: begin
                if (funct3 == 3'b001 || funct3 == 3'b101) begin
                    // Shift-immediate: upper bits act as funct7, only shamt reaches op_b.
                    dec_b = {{(XLEN-5){1'b0}}, instr[24:20]};
                    if (funct7 == F7_BASE) begin
                        legal = 1'b1;
                    end else if (funct7 == F7_ALT && funct3 == 3'b101) begin
                        legal  = 1'b1;
                        dec_op = ALU_SRA;
                    end
                end else begin
                    legal = 1'b1;
                    dec_b = {{(XLEN-12){instr[31]}}, instr[31:20]};
                end
            end
            default: legal = 1'b0;
        endcase

        dec = '0;
        if (legal) begin
            dec.alu_op  = dec_op;
            dec.op_a    = rs1_data;
            dec.op_b    = dec_b;
            dec.rd_addr = instr[11:7];
        end else begin
            // Illegal words still issue, but as a harmless ADD x0 with zero operands.
            dec.alu_op  = ALU_ADD;
            dec.illegal = 1'b1;
        end
    end

    always_comb begin
        issue_valid_d = issue_valid_q;
        issue_d       = issue_q;
        if (accept) begin
            issue_valid_d = 1'b1;
            issue_d       = dec;
        end else if (issue_ready) begin
            issue_valid_d = 1'b0;
        end
        if (flush) begin
            issue_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            issue_valid_q <= 1'b0;
            issue_q       <= '0;
        end else begin
            issue_valid_q <= issue_valid_d;
            issue_q       <= issue_d;
        end
    end

    assign issue_valid = issue_valid_q;
    assign alu_op      = issue_q.alu_op;
    assign op_a        = issue_q.op_a;
    assign op_b        = issue_q.op_b;
    assign rd_addr     = issue_q.rd_addr;
    assign illegal     = issue_q.illegal;

endmodule

// File: doc/rv_alu_issue.md
Name: rv_alu_issue

Overview:
- Decode/issue stage that drives the `rv_alu` operand and opcode interface. It is the producer side of the `op_in`/`rs1`/`rs2` contract.
- Accepts 32-bit RV32I OP and OP-IMM instruction words over a valid/ready handshake.
- Holds the 32x32 integer register file, with a writeback port and write-to-read bypass.
- Presents a registered issue bundle (ALU opcode, two operands, rd) to the execute stage with its own valid/ready handshake.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.
- NREGS, 32, register count; x0 is hardwired to zero.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- instr_valid  in  1  instruction word is valid.
- instr  in  32  RV32I instruction word.
- instr_ready  out  1  stage accepts `instr` this cycle.
- wb_en  in  1  register-file write enable.
- wb_addr  in  5  write register index.
- wb_data  in  32  write data.
- flush  in  1  discards the held issue bundle.
- issue_valid  out  1  issue bundle is valid.
- issue_ready  in  1  execute stage consumes the bundle.
- alu_op  out  4  ALU opcode (shared encoding).
- op_a  out  32  rs1 value.
- op_b  out  32  rs2 value, sign-extended immediate, or zero-extended shamt.
- rd_addr  out  5  destination register; 0 if illegal.
- illegal  out  1  instruction is not a supported OP/OP-IMM encoding.

Behaviour:
- Reset (synchronous, active-high): issue_valid=0, alu_op=0000, op_a=0, op_b=0, rd_addr=0, illegal=0, all registers x1..x31 = 0. A reset mid-transfer drops the held bundle.
- Handshake:
  - instr_ready = !issue_valid || issue_ready. It is combinational and does not depend on instr_valid.
  - A transfer occurs when instr_valid && instr_ready. The bundle is registered, so latency is 1 cycle from acceptance to issue_valid.
  - When issue_valid && !issue_ready, all outputs hold stable and instr_ready=0.
  - Back-to-back acceptance gives one instruction per cycle.
- Flush:
  - issue_valid clears on the next edge; output data is don't-care.
  - An instruction accepted in the same cycle as flush is discarded, so issue_valid=0 afterwards.
  - Flush has no effect on the register file.
- Register file:
  - Written on the edge when wb_en is high and wb_addr != 0. Writes to x0 are ignored.
  - Reads during decode use combinational bypass: if wb_en && wb_addr == rs && rs != 0, the operand is wb_data.
  - Reads of x0 always return 0.
  - Writeback proceeds regardless of the handshake state.
- Decode, opcode 0110011 (OP):
  - funct3 000: ADD, or SUB when funct7 = 0100000.
  - funct3 001: SLL. funct3 010: SLT. funct3 011: SLTU. funct3 100: XOR.
  - funct3 101: SRL, or SRA when funct7 = 0100000.
  - funct3 110: OR. funct3 111: AND.
  - Any funct7 other than 0000000, or 0100000 with funct3 000/101, sets illegal.
- Decode, opcode 0010011 (OP-IMM):
  - Same funct3 map, except funct3 000 is always ADD (there is no SUBI).
  - op_b = sign-extended instr[31:20].
  - Shifts (funct3 001/101): op_b = {27'b0, instr[24:20]}; instr[31:25] must be 0000000, or 0100000 for SRAI only. Anything else is illegal.
- Illegal handling:
  - Applies to any other opcode or a bad funct7.
  - The bundle is still issued with illegal=1, alu_op=ADD, rd_addr=0, op_a=op_b=0.
  - No side effects.
- op_a is always the rs1 value. rd_addr = instr[11:7].

Decomposition:
- Shared package `rv_defs`: the ALU opcode constants (ADD 0000, SUB 0001, XOR 0010, OR 0011, AND 0100, SLL 0101, SRL 0111, SRA 1000, SLT 1001, SLTU 1010), opcode constants OP=0110011 and OP_IMM=0010011, and funct7 constants. The same package is also consumed by `rv_alu`.
- One sub-module, `rv_regfile`: 2 read ports, 1 write port, bypass, x0 hardwired.

Test Plan:
- Write x1=5 and x2=3 via wb, then issue `add x3,x1,x2` (0x002081B3) -> 1 cycle later: issue_valid=1, alu_op=0000, op_a=5, op_b=3, rd_addr=3.
- Issue `sub` (0x402081B3), then `srai x4,x1,2` (0x4020D213) -> alu_op=0001 with op_b=3; then alu_op=1000 with op_b=2.
- Issue `addi x5,x0,-1` (0xFFF00293) -> alu_op=0000, op_a=0, op_b=0xFFFFFFFF.
- Hold issue_ready=0 for 3 cycles with instr_valid=1 -> instr_ready=0 and outputs stable; on release, the next instruction is accepted the same cycle.
- Apply wb_en=1, wb_addr=1, wb_data=0xA5 in the same cycle as accepting `add x3,x1,x1` -> op_a=op_b=0xA5. Same with wb_addr=0 -> op_a=0.
- Issue opcode 0x00000033 with funct7=0000001 (0x02000033) -> illegal=1, alu_op=0000, rd_addr=0. Then assert flush with a pending bundle -> issue_valid=0 next cycle.
